config_bank_loader: RTL

//   Configuration-protocol front end for the logical-tile memory bank.

---
 rtl/config_bank_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/config_bank_loader.sv
// Serial (address, data) bitstream loader. It turns each word into one enable/address/data_in latch write.
// One word takes ADDR_WIDTH+1 accepts plus 3 cycles. bs_ready is low outside ADDR/DATA, so no bits are taken then.
module config_bank_loader #(
  parameter int NUM_MEM    = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_WORDS  = 4
) (
  input  logic                           prog_clk_i,
  input  logic                           pReset_i,
  input  logic                           start_i,
  input  logic                           bs_valid_i,
  input  logic                           bs_data_i,
  output logic                           bs_ready_o,
  output logic                           enable_o,
  output logic [NUM_MEM-1:0]             address_o,
  output logic                           data_in_o,
  output logic [$clog2(NUM_WORDS+1)-1:0] word_count_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int BW = $clog2(ADDR_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_SETUP = 3'd3,
    S_WRITE = 3'd4,
    S_HOLD  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic                  in_range_q, in_range_d;
  logic [NUM_MEM-1:0]    address_q, address_d;
  logic                  data_in_q, data_in_d;
  logic                  enable_q, enable_d;
  logic                  bs_ready_q, bs_ready_d;
  logic [CW-1:0]         wc_q, wc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  addr_ok;
  logic [CW-1:0]         wc_inc;

  assign accept  = bs_valid_i & bs_ready_q;
  assign addr_ok = (int'(addr_sr_q) < NUM_MEM);
  assign wc_inc  = (wc_q < CW'(NUM_WORDS)) ? wc_q + CW'(1) : wc_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sr_d  = addr_sr_q;
    in_range_d = in_range_q;
    address_d  = address_q;
    data_in_d  = data_in_q;
    enable_d   = 1'b0;
    wc_d       = wc_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_ADDR;
          bit_cnt_d = '0;
          wc_d      = '0;
          err_d     = 1'b0;
          done_d    = 1'b0;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_sr_d = ADDR_WIDTH'({addr_sr_q, bs_data_i});
          if (bit_cnt_q == BW'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_DATA: begin
        // Address/data_in are loaded on the edge into SETUP so they are
        // already stable for the whole SETUP cycle ahead of the strobe.
        if (accept) begin
          state_d    = S_SETUP;
          in_range_d = addr_ok;
          if (addr_ok) begin
            address_d = NUM_MEM'(1) << addr_sr_q;
            data_in_d = bs_data_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d  = S_WRITE;
        enable_d = in_range_q;
      end
      S_WRITE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        wc_d = wc_inc;
        if (wc_inc == CW'(NUM_WORDS)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ADDR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bs_ready_d = (state_d == S_ADDR) || (state_d == S_DATA);
  end

  always_ff @(posedge prog_clk_i) begin
    if (pReset_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      addr_sr_q  <= '0;
      in_range_q <= 1'b0;
      address_q  <= '0;
      data_in_q  <= 1'b0;
      enable_q   <= 1'b0;
      bs_ready_q <= 1'b0;
      wc_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_sr_q  <= addr_sr_d;
      in_range_q <= in_range_d;
      address_q  <= address_d;
      data_in_q  <= data_in_d;
      enable_q   <= enable_d;
      bs_ready_q <= bs_ready_d;
      wc_q       <= wc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bs_ready_o   = bs_ready_q;
  assign enable_o     = enable_q;
  assign address_o    = address_q;
  assign data_in_o    = data_in_q;
  assign word_count_o = wc_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
